// File: rtl/key_uart_sender.sv
// key_uart_sender: queues 4-bit key codes and paces them out as ASCII hex
// (plus optional CR LF) to a UART transmitter that has no busy/done signal.
//
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   key_valid       - one-cycle strobe qualifying key_code
//   key_code[3:0]   - key index 0..15
//   tx_data[7:0]    - byte to the transmitter, held between starts
//   tx_start        - one-cycle start pulse, one per frame pitch
//   busy            - FIFO non-empty or a key in flight
//   overflow        - sticky, set when a key is dropped on a full FIFO
module key_uart_sender #(
  parameter int CLK_FREQ    = 50000000,
  parameter int UART_BPS    = 115200,
  parameter int FIFO_DEPTH  = 8,
  parameter int APPEND_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       overflow
);

  localparam int PERIOD       = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYCLES = 10 * PERIOD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = $clog2(FRAME_CYCLES);

  // Leaving WAIT on FRAME_CYCLES-2 makes SEND-to-SEND exactly one frame.
  localparam logic [CW-1:0] WAIT_LAST = CW'(FRAME_CYCLES - 2);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [3:0]      code_q, code_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [7:0]      data_q, data_d;
  logic            ovf_q, ovf_d;

  logic            pop;
  logic            push;
  logic            full;
  logic            more;
  logic [7:0]      ascii;
  logic [7:0]      cur_byte;

  always_comb begin
    if (code_q < 4'd10) ascii = 8'h30 + {4'h0, code_q};
    else                ascii = 8'h37 + {4'h0, code_q};
  end

  always_comb begin
    unique case (1'b1)
      idx_q == 2'd1: cur_byte = 8'h0D;
      idx_q == 2'd2: cur_byte = 8'h0A;
      default:       cur_byte = ascii;
    endcase
  end

  assign more = (APPEND_CRLF != 0) && (idx_q < 2'd2);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    data_d   = data_q;
    pop      = 1'b0;
    tx_start = 1'b0;
    tx_data  = data_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          code_d  = mem_q[rd_ptr_q];
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_start = 1'b1;
        tx_data  = cur_byte;
        data_d   = cur_byte;
        wcnt_d   = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          if (more) begin
            idx_d   = idx_q + 2'd1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    full     = (count_q == FULL_CNT);
    push     = key_valid && (!full || pop);
    ovf_d    = ovf_q | (key_valid & full & ~pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      code_q   <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= key_code;
    end
  end

  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_uart_sender.sv
// tb_key_uart_sender: directed table, corner sequences and random traffic
// on a CRLF instance (index 1) and a character-only instance (index 0).
module tb_key_uart_sender;

  localparam int F     = 100;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       kv  [2];
  logic [3:0] kc  [2];
  logic [7:0] txd [2];
  logic       txs [2];
  logic       bsy [2];
  logic       ovf [2];

  key_uart_sender #(
    .CLK_FREQ(1000), .UART_BPS(100),
    .FIFO_DEPTH(DEPTH), .APPEND_CRLF(1)
  ) u_crlf (
    .clk(clk), .rst_n(rst_n),
    .key_valid(kv[1]), .key_code(kc[1]),
    .tx_data(txd[1]), .tx_start(txs[1]),
    .busy(bsy[1]), .overflow(ovf[1])
  );

  key_uart_sender #(
    .CLK_FREQ(1000), .UART_BPS(100),
    .FIFO_DEPTH(DEPTH), .APPEND_CRLF(0)
  ) u_raw (
    .clk(clk), .rst_n(rst_n),
    .key_valid(kv[0]), .key_code(kc[0]),
    .tx_data(txd[0]), .tx_start(txs[0]),
    .busy(bsy[0]), .overflow(ovf[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  string hexc = "0123456789ABCDEF";

  // reference model: key queue plus a schedule of expected start pulses
  logic [3:0] mf [2][DEPTH];
  int         mhead [2];
  int         mcnt [2];
  int         free_at [2];
  int         ep_cyc [2][3];
  logic [7:0] ep_dat [2][3];
  int         ep_len [2];
  logic [7:0] mlast [2];
  logic       movf [2];

  // observed pulses
  int         pc [2][64];
  logic [7:0] pd [2][64];
  int         pn [2];

  task automatic cmp(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; mcnt[i] = 0; free_at[i] = 0;
      ep_len[i] = 0; mlast[i] = 8'h00; movf[i] = 1'b0;
    end
  endtask

  task automatic model_cycle(input int i, input logic v,
                             input logic [3:0] c);
    logic       es;
    logic [7:0] ed;
    logic       full;
    logic       pop;
    logic [3:0] code;
    es = 1'b0;
    ed = mlast[i];
    for (int k = 0; k < ep_len[i]; k++)
      if (ep_cyc[i][k] == cyc) begin
        es = 1'b1;
        ed = ep_dat[i][k];
      end
    mlast[i] = ed;
    cmp($sformatf("tx_start[%0d]", i), int'(txs[i]), int'(es));
    cmp($sformatf("tx_data[%0d]", i), int'(txd[i]), int'(ed));
    cmp($sformatf("busy[%0d]", i), int'(bsy[i]),
        int'((cyc < free_at[i]) || (mcnt[i] != 0)));
    cmp($sformatf("overflow[%0d]", i), int'(ovf[i]), int'(movf[i]));
    if (txs[i]) begin
      if (pn[i] < 64) begin
        pc[i][pn[i]] = cyc;
        pd[i][pn[i]] = txd[i];
      end
      pn[i]++;
    end
    full = (mcnt[i] == DEPTH);
    pop  = (cyc >= free_at[i]) && (mcnt[i] > 0);
    if (pop) begin
      code = mf[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % DEPTH;
      mcnt[i]--;
      ep_cyc[i][0] = cyc + 1;
      ep_dat[i][0] = hexc[code];
      if (i == 1) begin
        ep_cyc[i][1] = cyc + 1 + F;     ep_dat[i][1] = 8'h0D;
        ep_cyc[i][2] = cyc + 1 + 2 * F; ep_dat[i][2] = 8'h0A;
        ep_len[i] = 3;
        free_at[i] = cyc + 1 + 3 * F;
      end else begin
        ep_len[i] = 1;
        free_at[i] = cyc + 1 + F;
      end
    end
    if (v) begin
      if (!full || pop) begin
        mf[i][(mhead[i] + mcnt[i]) % DEPTH] = c;
        mcnt[i]++;
      end else begin
        movf[i] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v1, input logic [3:0] c1,
                      input logic v0, input logic [3:0] c0);
    kv[1] = v1; kc[1] = c1;
    kv[0] = v0; kc[0] = c0;
    @(negedge clk);
    model_cycle(1, v1, c1);
    model_cycle(0, v0, c0);
    @(posedge clk);
    #1;
    cyc++;
    kv[0] = 1'b0;
    kv[1] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    kv[0] = 1'b0;
    kv[1] = 1'b0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("rst_tx_start[%0d]", i), int'(txs[i]), 0);
        cmp($sformatf("rst_tx_data[%0d]", i), int'(txd[i]), 0);
        cmp($sformatf("rst_busy[%0d]", i), int'(bsy[i]), 0);
        cmp($sformatf("rst_overflow[%0d]", i), int'(ovf[i]), 0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int i, input int bound, output int fall);
    int k;
    k = 0;
    while (bsy[i] && k < bound) begin
      idle(1);
      k++;
    end
    fall = cyc;
  endtask

  typedef struct {
    int         inst;
    logic [3:0] code;
    logic [7:0] ch;
  } vec_t;

  initial begin
    vec_t       tbl [6];
    logic [7:0] seq [6];
    int         n;
    int         fall;
    int         i;
    int         k;
    logic       v1;
    logic       v0;

    tbl[0] = '{1, 4'h5, 8'h35};
    tbl[1] = '{0, 4'hC, 8'h43};
    tbl[2] = '{1, 4'hA, 8'h41};
    tbl[3] = '{0, 4'h9, 8'h39};
    tbl[4] = '{1, 4'hF, 8'h46};
    tbl[5] = '{0, 4'h0, 8'h30};
    seq[0] = 8'h30; seq[1] = 8'h0D; seq[2] = 8'h0A;
    seq[3] = 8'h46; seq[4] = 8'h0D; seq[5] = 8'h0A;

    rst_n = 1'b0;
    kv[0] = 1'b0; kv[1] = 1'b0;
    kc[0] = 4'h0; kc[1] = 4'h0;
    pn[0] = 0; pn[1] = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset_cycles(3);
    idle(500);
    cmp("quiet_after_reset", pn[0] + pn[1], 0);

    for (int t = 0; t < 6; t++) begin
      i = tbl[t].inst;
      pn[i] = 0;
      n = cyc;
      if (i == 1) step(1'b1, tbl[t].code, 1'b0, 4'h0);
      else        step(1'b0, 4'h0, 1'b1, tbl[t].code);
      wait_idle(i, 400, fall);
      cmp($sformatf("tbl%0d_pulses", t), pn[i], (i == 1) ? 3 : 1);
      cmp($sformatf("tbl%0d_char_at", t), pc[i][0] - n, 2);
      cmp($sformatf("tbl%0d_char", t), int'(pd[i][0]), int'(tbl[t].ch));
      if (i == 1) begin
        cmp($sformatf("tbl%0d_cr_at", t), pc[i][1] - n, 102);
        cmp($sformatf("tbl%0d_cr", t), int'(pd[i][1]), 8'h0D);
        cmp($sformatf("tbl%0d_lf_at", t), pc[i][2] - n, 202);
        cmp($sformatf("tbl%0d_lf", t), int'(pd[i][2]), 8'h0A);
      end
      cmp($sformatf("tbl%0d_busy_fall", t), fall - n,
          (i == 1) ? 302 : 102);
    end

    // back-to-back keys
    pn[1] = 0;
    step(1'b1, 4'h0, 1'b0, 4'h0);
    step(1'b1, 4'hF, 1'b0, 4'h0);
    wait_idle(1, 900, fall);
    cmp("b2b_pulses", pn[1], 6);
    for (int j = 0; j < 6; j++)
      cmp($sformatf("b2b_byte%0d", j), int'(pd[1][j]), int'(seq[j]));
    cmp("b2b_gap", pc[1][3] - pc[1][2], 101);

    // overflow: ten strobes, nine accepted
    pn[1] = 0;
    for (int j = 0; j < 10; j++) step(1'b1, 4'(j), 1'b0, 4'h0);
    cmp("ovf_set", int'(ovf[1]), 1);
    wait_idle(1, 3000, fall);
    cmp("ovf_pulses", pn[1], 27);
    for (int j = 0; j < 9; j++)
      cmp($sformatf("ovf_char%0d", j), int'(pd[1][3 * j]), 8'h30 + j);
    cmp("ovf_sticky", int'(ovf[1]), 1);
    reset_cycles(2);

    // push on a full FIFO in the same cycle as a pop
    pn[1] = 0;
    n = cyc;
    step(1'b1, 4'h1, 1'b0, 4'h0);
    for (int j = 2; j < 10; j++) step(1'b1, 4'(j), 1'b0, 4'h0);
    cmp("fill_no_ovf", int'(ovf[1]), 0);
    k = 0;
    while (cyc < n + 302 && k < 400) begin
      idle(1);
      k++;
    end
    step(1'b1, 4'hA, 1'b0, 4'h0);
    cmp("full_pop_push_ovf", int'(ovf[1]), 0);
    k = 0;
    while (pn[1] < 28 && k < 3500) begin
      idle(1);
      k++;
    end
    cmp("full_pop_push_char", int'(pd[1][27]), 8'h41);
    idle(50);
    reset_cycles(3);
    pn[0] = 0; pn[1] = 0;
    idle(400);
    cmp("no_start_after_abort", pn[1], 0);

    // random traffic: sparse then dense
    for (int j = 0; j < 6000; j++) begin
      if (j < 3000) begin
        v1 = ($urandom_range(0, 399) == 0);
        v0 = ($urandom_range(0, 149) == 0);
      end else begin
        v1 = ($urandom_range(0, 39) == 0);
        v0 = ($urandom_range(0, 19) == 0);
      end
      step(v1, 4'($urandom_range(0, 15)), v0, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/key_uart_sender.md
# key_uart_sender

Packetizer stage directly upstream of the UART transmitter. Accepts 4-bit key codes from the matrix-keyboard scanner, buffers them in a small FIFO, converts each to ASCII hex, and optionally appends CR LF. It drives the transmitter's `data`/`tx_start` pair with one-cycle start pulses at a fixed frame pitch, because the transmitter exposes no busy/done signal.

## Interface
- `CLK_FREQ`, default 50000000: system clock in Hz.
- `UART_BPS`, default 115200: baud rate; must match the downstream transmitter.
- `FIFO_DEPTH`, default 8: key-code FIFO depth; power of two, ≥2.
- `APPEND_CRLF`, default 1: 1 = send 0x0D, 0x0A after each character; 0 = character only.
- Derived: `PERIOD = CLK_FREQ/UART_BPS` (integer division); `FRAME_CYCLES = 10*PERIOD`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid this cycle.
- `key_code` in 4: key index 0–15.
- `tx_data` out 8: byte to transmit; connects to the transmitter's `data`.
- `tx_start` out 1: one-cycle start pulse; connects to the transmitter's `tx_start`.
- `busy` out 1: high while the FIFO is non-empty or a key is being sent.
- `overflow` out 1: sticky; set when a key is dropped, cleared only by reset.

## Operation
- FIFO: `FIFO_DEPTH` × 4 bits, with read and write pointers and an occupancy count of `log2(FIFO_DEPTH)+1` bits. Pointers wrap modulo depth.
- Write: a write is accepted when `key_valid`=1 and (not full, or a pop occurs in the same cycle). If `key_valid`=1, the FIFO is full, and no pop occurs, the key is dropped and `overflow` is set to 1.
- A simultaneous push and pop leaves the count unchanged.
- ASCII mapping:
  - codes 0–9 → 0x30+code.
  - codes 10–15 → 0x41+(code−10), giving 'A'–'F'.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - If the FIFO is non-empty, pop it, latch the code, set byte index = 0, and go to SEND.
  - Otherwise stay in IDLE.
- SEND (one cycle):
  - `tx_start`=1.
  - `tx_data` = the byte selected by the index: 0 → ASCII character, 1 → 0x0D, 2 → 0x0A.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - When the counter reaches `FRAME_CYCLES`−2, the next action depends on what remains to send:
    - if more bytes remain for this key (index < 2 with CRLF enabled), increment the index and go to SEND;
    - otherwise go to IDLE.
- `tx_data` holds its last value outside SEND. It changes only on the SEND cycle.
- `busy` = (state ≠ IDLE) or (count ≠ 0); combinational from registers.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0x00, `busy`=0, `overflow`=0, FIFO empty, state IDLE, index 0, counters 0.
- Reset mid-frame aborts immediately; no further `tx_start` occurs until new keys arrive.
- Latency: `key_valid` in cycle n with the block idle and the FIFO empty gives:
  - FIFO written at the end of cycle n;
  - pop in cycle n+1;
  - `tx_start`=1 with the ASCII byte in cycle n+2.
- Spacing:
  - Consecutive `tx_start` pulses for the same key are exactly `FRAME_CYCLES` apart.
  - The first pulse of the next queued key comes `FRAME_CYCLES`+1 after the previous key's last pulse (one IDLE cycle).
  - This guarantees a full stop bit plus idle margin at the transmitter.
- `tx_start` is never high on two consecutive cycles.
- `tx_start` is never asserted while the FIFO is empty and the state is IDLE.
- `busy` rises in cycle n+1 after the first accepted write. It falls the cycle after the final WAIT expires with the FIFO empty.
- A `key_valid` arriving during SEND or WAIT is queued and does not disturb the current transmission.

## Test plan
The bench uses `CLK_FREQ`=1000 and `UART_BPS`=100, so `PERIOD`=10 and `FRAME_CYCLES`=100.
- Reset check: hold `rst_n`=0 → all outputs zero. Release reset with no input → `tx_start` stays 0 for 500 cycles.
- Single key, `key_code`=5 at cycle n → `tx_start` pulses at n+2 (0x35), n+102 (0x0D), n+202 (0x0A). `busy` falls at n+302.
- `key_code`=12 with `APPEND_CRLF`=0 → a single pulse with 0x43 at n+2. No further pulses.
- Back-to-back keys 0x0 then 0xF on consecutive cycles → byte sequence 0x30, 0x0D, 0x0A, 0x46, 0x0D, 0x0A. The 0x46 pulse comes 101 cycles after the first key's 0x0A pulse.
- Overflow: 10 strobes with codes 0–9 while idle, FIFO_DEPTH=8.
  - The first key is popped before the FIFO fills, so 9 keys are accepted (codes 0–8); code 9 is dropped.
  - `overflow`=1 and stays 1 after draining.
  - Output characters are '0'–'8' in order.
- Push while full in the same cycle as a pop → the key is accepted and `overflow` stays 0. Assert `rst_n`=0 mid-WAIT → `tx_start` is never asserted again and `busy`=0 immediately.
